mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_LATENCY, default 2, cycles from load acceptance to response; legal range 1..15.
REQ-002 Parameter MEM_DEPTH_BITS, default 10, log2 of number of 64-bit lines held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cache2mem_addr  input  `XLEN  byte address; line index = addr[MEM_DEPTH_BITS+2:3]; word select = addr[2].
REQ-006 cache2mem_data  input  `XLEN  store data, one 32-bit word.
REQ-007 dcache2mem_command  input  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE.
REQ-008 mem2cache_valid  output  1  one-cycle pulse marking load response.
REQ-009 mem2cache_data  output  64  full line for the accepted load; meaningful only while mem2cache_valid=1.
REQ-010 mem_error  output  1  out-of-range access flag; see Configuration.

Function
REQ-011 Storage: 2**MEM_DEPTH_BITS lines x 64 bits; the array is not cleared by rst.
REQ-012 FSM states: IDLE, BUSY, RESPOND.
REQ-013 IDLE + BUS_LOAD sampled at an edge -> capture line index, load countdown counter with MEM_LATENCY-1, go BUSY; if MEM_LATENCY=1, go directly to RESPOND.
REQ-014 BUSY: decrement counter each edge; at 0 go RESPOND.
REQ-015 mem2cache_valid SHALL be 1 exactly in the cycle the FSM is in RESPOND, i.e. MEM_LATENCY cycles after the accepting edge; RESPOND -> IDLE unconditionally next edge.
REQ-016 mem2cache_data in RESPOND = array[captured index] read combinationally in that cycle (includes any store completed earlier); 0 in all other cycles.
REQ-017 BUS_LOAD held asserted during BUSY/RESPOND is the same request; no second acceptance; address changes during BUSY are ignored.
REQ-018 BUS_LOAD present in IDLE the cycle after RESPOND is a new request (accepted).
REQ-019 BUS_STORE in any state writes cache2mem_data into word addr[2] of array[index] at that edge (addr[2]=1 -> [63:32], else [31:0]); other word unchanged; no valid pulse; FSM state unaffected.
REQ-020 BUS_STORE to the captured line while BUSY is visible in the subsequent response.
REQ-021 BUS_NONE: no state change except BUSY countdown.

Reset
REQ-022 rst=1 at an edge -> FSM IDLE, counter 0, captured index 0, mem2cache_valid 0, mem2cache_data 0, mem_error 0.
REQ-023 rst during BUSY or RESPOND aborts the pending load; no valid pulse follows; a load held across reset release is accepted at the first edge with rst=0.
REQ-024 rst=1 blocks stores; the array is not written.

Configuration
REQ-025 Macro MEM_BOUNDS_CHECK_EN defined: access with addr[`XLEN-1:MEM_DEPTH_BITS+3] != 0 is out of range; an out-of-range store is dropped; an out-of-range load still completes with latency but returns data 0; mem_error = 1 for one cycle in the store's following cycle or in the load's RESPOND cycle.
REQ-026 Macro undefined: upper address bits are ignored (aliasing onto index); mem_error is tied 0.

Verification
REQ-027 Reset, then BUS_LOAD addr 0x40 held, MEM_LATENCY=2 -> valid high only in 2nd cycle after acceptance, data = array[8]; exactly one pulse despite held command.
REQ-028 BUS_STORE addr 0x44 data 0xDEADBEEF, then load 0x40 -> data[63:32]=0xDEADBEEF, data[31:0] unchanged.
REQ-029 Load 0x80 accepted; store 0x80 data 0x12345678 while BUSY -> response data[31:0]=0x12345678.
REQ-030 Load accepted, rst pulsed in BUSY -> no valid pulse; next load behaves normally.
REQ-031 MEM_LATENCY=1, back-to-back loads 0x0 then 0x8 -> valid pulses in consecutive alternate cycles with correct lines.
REQ-032 With MEM_BOUNDS_CHECK_EN, MEM_DEPTH_BITS=10, load 0x2000 -> data 0, mem_error=1 with valid; store 0x2000 -> array unchanged, mem_error pulse.

Source files
------------

// File: rtl/mem_responder.sv
// Line-oriented memory model answering cache loads after a fixed latency and accepting word stores.
// Optional build macro MEM_BOUNDS_CHECK_EN enables out-of-range detection and the mem_error flag.
`ifndef XLEN
`define XLEN 32
`endif

package mem_responder_pkg;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_command_t;
endpackage

module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned MEM_LATENCY    = 2,
   parameter int unsigned MEM_DEPTH_BITS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [`XLEN-1:0] cache2mem_addr,
   input  logic [`XLEN-1:0] cache2mem_data,
   input  bus_command_t     dcache2mem_command,
   output logic             mem2cache_valid,
   output logic [63:0]      mem2cache_data,
   output logic             mem_error
);
   localparam int unsigned CNT_W = 4;
   localparam int unsigned IDX_W = MEM_DEPTH_BITS;
   localparam int unsigned LINES = 1 << MEM_DEPTH_BITS;

   typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt;
   logic             r_oob, w_oob_nxt;
   logic [63:0]      r_mem [LINES];
   logic [IDX_W-1:0] w_idx;
   logic             w_oob;
   logic             w_store;
   logic             w_unused;

   assign w_idx = cache2mem_addr[IDX_W+2:3];

`ifdef MEM_BOUNDS_CHECK_EN
   logic r_err_st;

   assign w_oob    = |cache2mem_addr[`XLEN-1:IDX_W+3];
   assign w_unused = ^cache2mem_addr[1:0];

   // Dropped store is flagged in the cycle after its edge
   always_ff @(posedge clk) begin
      if (rst) r_err_st <= 1'b0;
      else     r_err_st <= (dcache2mem_command == BUS_STORE) && w_oob;
   end

   assign mem_error = r_err_st | ((r_state == RESPOND) & r_oob);
`else
   assign w_oob     = 1'b0;
   assign w_unused  = ^{cache2mem_addr[`XLEN-1:IDX_W+3], cache2mem_addr[1:0]};
   assign mem_error = 1'b0;
`endif

   assign w_store = !rst && (dcache2mem_command == BUS_STORE) && !w_oob;

   // Word-granular store; array contents survive reset
   always_ff @(posedge clk) begin
      if (w_store) begin
         if (cache2mem_addr[2]) r_mem[w_idx][63:32] <= 32'(cache2mem_data);
         else                   r_mem[w_idx][31:0]  <= 32'(cache2mem_data);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_oob   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_oob   <= w_oob_nxt;
      end
   end

   // Counter holds edges remaining until RESPOND is entered
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_oob_nxt   = r_oob;
      case (r_state)
         IDLE: begin
            if (dcache2mem_command == BUS_LOAD) begin
               w_idx_nxt   = w_idx;
               w_oob_nxt   = w_oob;
               w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
               w_state_nxt = (MEM_LATENCY == 1) ? RESPOND : BUSY;
            end
         end
         BUSY: begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) w_state_nxt = RESPOND;
         end
         RESPOND: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Response reads the array live so stores made while BUSY are included
   assign mem2cache_valid = (r_state == RESPOND);
   assign mem2cache_data  = (mem2cache_valid && !r_oob) ? r_mem[r_idx] : 64'h0;

endmodule
